rv64ima_soc: RTL and testbench

- Single-issue, single-cycle RV64 integer core with the M (multiply/divide) and A (atomic, doubleword) extensions.
- Instruction and data memories are external: the core fetches from `instr_in`, reads load/AMO data from `data_in`, and drives address, store data and write strobe.
- It is the integer datapath top of the SoC; the FPU is a separate block.

---
 rtl/rv64ima_soc.sv | 265 ++++++++++++++++++++++++++
 tb/tb_rv64ima_soc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rv64ima_soc.sv
// rv64ima_soc: single-cycle RV64IMA integer core. Each clock edge retires one instruction.
// Instruction and data memories are external; loads, LR and AMOs read data_in combinationally.
module rv64ima_soc #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [63:0]     instr_in,
    input  logic [XLEN-1:0] data_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] data_out,
    output logic            mem_write
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_AMO    = 7'b0101111;

    logic [XLEN-1:0] registers [32];
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_data_out;
    logic            r_mem_write;
    logic            r_resv_valid;
    logic [XLEN-1:0] r_resv_addr;

    assign pc_out     = r_pc;
    assign alu_result = r_alu_result;
    assign data_out   = r_data_out;
    assign mem_write  = r_mem_write;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd, w_rs1, w_rs2, w_funct5;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_pc_plus4;

    assign w_opcode = instr_in[6:0];
    assign w_rd     = instr_in[11:7];
    assign w_funct3 = instr_in[14:12];
    assign w_rs1    = instr_in[19:15];
    assign w_rs2    = instr_in[24:20];
    assign w_funct7 = instr_in[31:25];
    assign w_funct5 = instr_in[31:27];

    assign w_imm_i = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
    assign w_imm_s = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign w_imm_b = {{(XLEN-13){instr_in[31]}}, instr_in[31], instr_in[7],
                      instr_in[30:25], instr_in[11:8], 1'b0};
    assign w_imm_u = {{(XLEN-32){instr_in[31]}}, instr_in[31:12], 12'b0};
    assign w_imm_j = {{(XLEN-21){instr_in[31]}}, instr_in[31], instr_in[19:12],
                      instr_in[20], instr_in[30:21], 1'b0};

    assign w_rs1_val  = (w_rs1 == 5'd0) ? '0 : registers[w_rs1];
    assign w_rs2_val  = (w_rs2 == 5'd0) ? '0 : registers[w_rs2];
    assign w_pc_plus4 = r_pc + XLEN'(4);

    // Base integer ALU shared by OP and OP-IMM; bit 30 selects SUB and SRA.
    logic [XLEN-1:0] w_alu_b, w_alu_out;
    logic [5:0]      w_shamt;
    assign w_alu_b = (w_opcode == OPC_OP) ? w_rs2_val : w_imm_i;
    assign w_shamt = w_alu_b[5:0];

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_alu_out = '0;
        case (w_funct3)
            3'b000: w_alu_out = (w_opcode == OPC_OP && instr_in[30]) ? w_rs1_val - w_alu_b
                                                                    : w_rs1_val + w_alu_b;
            3'b001: w_alu_out = w_rs1_val << w_shamt;
            3'b010: w_alu_out = {{(XLEN-1){1'b0}}, $signed(w_rs1_val) < $signed(w_alu_b)};
            3'b011: w_alu_out = {{(XLEN-1){1'b0}}, w_rs1_val < w_alu_b};
            3'b100: w_alu_out = w_rs1_val ^ w_alu_b;
            3'b101: w_alu_out = instr_in[30] ? XLEN'($signed(w_rs1_val) >>> w_shamt)
                                             : w_rs1_val >> w_shamt;
            3'b110: w_alu_out = w_rs1_val | w_alu_b;
            default: w_alu_out = w_rs1_val & w_alu_b;
        endcase
    end

    // Products on 128-bit extended operands; the low 128 bits are exact for every signedness.
    logic [2*XLEN-1:0] w_prod_uu, w_prod_ss, w_prod_su;
    assign w_prod_uu = {{XLEN{1'b0}}, w_rs1_val} * {{XLEN{1'b0}}, w_rs2_val};
    assign w_prod_ss = {{XLEN{w_rs1_val[XLEN-1]}}, w_rs1_val} * {{XLEN{w_rs2_val[XLEN-1]}}, w_rs2_val};
    assign w_prod_su = {{XLEN{w_rs1_val[XLEN-1]}}, w_rs1_val} * {{XLEN{1'b0}}, w_rs2_val};

    // Divisor is forced to 1 in the zero/overflow corner cases so the divider never sees them.
    logic            w_div_zero, w_div_ovf;
    logic [XLEN-1:0] w_sdiv_b, w_udiv_b, w_quot_s, w_rem_s, w_quot_u, w_rem_u, w_mext_out;
    assign w_div_zero = (w_rs2_val == '0);
    assign w_div_ovf  = (w_rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (w_rs2_val == '1);
    assign w_sdiv_b   = (w_div_zero || w_div_ovf) ? XLEN'(1) : w_rs2_val;
    assign w_udiv_b   = w_div_zero ? XLEN'(1) : w_rs2_val;
    assign w_quot_s   = w_div_zero ? '1 : w_div_ovf ? w_rs1_val
                                     : XLEN'($signed(w_rs1_val) / $signed(w_sdiv_b));
    assign w_rem_s    = w_div_zero ? w_rs1_val : w_div_ovf ? '0
                                     : XLEN'($signed(w_rs1_val) % $signed(w_sdiv_b));
    assign w_quot_u   = w_div_zero ? '1 : w_rs1_val / w_udiv_b;
    assign w_rem_u    = w_div_zero ? w_rs1_val : w_rs1_val % w_udiv_b;

    always_comb begin
        w_mext_out = '0;
        case (w_funct3)
            3'b000: w_mext_out = w_prod_uu[XLEN-1:0];
            3'b001: w_mext_out = w_prod_ss[2*XLEN-1:XLEN];
            3'b010: w_mext_out = w_prod_su[2*XLEN-1:XLEN];
            3'b011: w_mext_out = w_prod_uu[2*XLEN-1:XLEN];
            3'b100: w_mext_out = w_quot_s;
            3'b101: w_mext_out = w_quot_u;
            3'b110: w_mext_out = w_rem_s;
            default: w_mext_out = w_rem_u;
        endcase
    end

    logic [XLEN-1:0] w_next_pc, w_result, w_store_data, w_rd_val, w_jalr_sum;
    logic            w_rd_we, w_mem_we, w_set_resv, w_clr_resv, w_taken;
    assign w_jalr_sum = w_rs1_val + w_imm_i;

    always_comb begin
        w_next_pc    = w_pc_plus4;
        w_result     = '0;
        w_store_data = '0;
        w_rd_val     = '0;
        w_rd_we      = 1'b0;
        w_mem_we     = 1'b0;
        w_set_resv   = 1'b0;
        w_clr_resv   = 1'b0;
        w_taken      = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_result = w_imm_u; w_rd_val = w_imm_u; w_rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                w_result = r_pc + w_imm_u; w_rd_val = r_pc + w_imm_u; w_rd_we = 1'b1;
            end
            OPC_JAL: begin
                w_next_pc = r_pc + w_imm_j;
                w_result  = w_pc_plus4; w_rd_val = w_pc_plus4; w_rd_we = 1'b1;
            end
            OPC_JALR: begin
                w_next_pc = {w_jalr_sum[XLEN-1:1], 1'b0};
                w_result  = w_pc_plus4; w_rd_val = w_pc_plus4; w_rd_we = 1'b1;
            end
            OPC_BRANCH: begin
                case (w_funct3)
                    3'b000: w_taken = (w_rs1_val == w_rs2_val);
                    3'b001: w_taken = (w_rs1_val != w_rs2_val);
                    3'b100: w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
                    3'b101: w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
                    3'b110: w_taken = (w_rs1_val <  w_rs2_val);
                    3'b111: w_taken = (w_rs1_val >= w_rs2_val);
                    default: w_taken = 1'b0;
                endcase
                w_result = r_pc + w_imm_b;
                if (w_taken) w_next_pc = r_pc + w_imm_b;
            end
            OPC_LOAD: begin
                w_result = w_rs1_val + w_imm_i;
                w_rd_we  = (w_funct3 != 3'b111);
                case (w_funct3)
                    3'b000: w_rd_val = {{(XLEN-8){data_in[7]}}, data_in[7:0]};
                    3'b001: w_rd_val = {{(XLEN-16){data_in[15]}}, data_in[15:0]};
                    3'b010: w_rd_val = {{(XLEN-32){data_in[31]}}, data_in[31:0]};
                    3'b011: w_rd_val = data_in;
                    3'b100: w_rd_val = {{(XLEN-8){1'b0}}, data_in[7:0]};
                    3'b101: w_rd_val = {{(XLEN-16){1'b0}}, data_in[15:0]};
                    3'b110: w_rd_val = {{(XLEN-32){1'b0}}, data_in[31:0]};
                    default: w_rd_val = '0;
                endcase
            end
            OPC_STORE: begin
                if (!w_funct3[2]) begin
                    w_result = w_rs1_val + w_imm_s; w_store_data = w_rs2_val; w_mem_we = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if ((w_funct3 == 3'b001 && instr_in[31:26] == 6'b000000) ||
                    (w_funct3 == 3'b101 && (instr_in[31:26] == 6'b000000 || instr_in[31:26] == 6'b010000)) ||
                    (w_funct3 != 3'b001 && w_funct3 != 3'b101)) begin
                    w_result = w_alu_out; w_rd_val = w_alu_out; w_rd_we = 1'b1;
                end
            end
            OPC_OP: begin
                if (w_funct7 == 7'b0000001) begin
                    w_result = w_mext_out; w_rd_val = w_mext_out; w_rd_we = 1'b1;
                end else if (w_funct7 == 7'b0000000 ||
                             (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
                    w_result = w_alu_out; w_rd_val = w_alu_out; w_rd_we = 1'b1;
                end
            end
            OPC_AMO: begin
                if (w_funct3 == 3'b011) begin
                    w_result = w_rs1_val;
                    w_rd_val = data_in;
                    w_rd_we  = 1'b1;
                    w_mem_we = 1'b1;
                    case (w_funct5)
                        5'b00010: begin w_mem_we = 1'b0; w_set_resv = 1'b1; end
                        5'b00011: begin
                            w_clr_resv = 1'b1;
                            if (r_resv_valid && r_resv_addr == w_rs1_val) begin
                                w_store_data = w_rs2_val; w_rd_val = '0;
                            end else begin
                                w_mem_we = 1'b0; w_rd_val = XLEN'(1);
                            end
                        end
                        5'b00001: w_store_data = w_rs2_val;
                        5'b00000: w_store_data = data_in + w_rs2_val;
                        5'b00100: w_store_data = data_in ^ w_rs2_val;
                        5'b01100: w_store_data = data_in & w_rs2_val;
                        5'b01000: w_store_data = data_in | w_rs2_val;
                        5'b10000: w_store_data = ($signed(data_in) < $signed(w_rs2_val)) ? data_in : w_rs2_val;
                        5'b10100: w_store_data = ($signed(data_in) > $signed(w_rs2_val)) ? data_in : w_rs2_val;
                        5'b11000: w_store_data = (data_in < w_rs2_val) ? data_in : w_rs2_val;
                        5'b11100: w_store_data = (data_in > w_rs2_val) ? data_in : w_rs2_val;
                        default: begin
                            w_result = '0; w_rd_val = '0; w_rd_we = 1'b0; w_mem_we = 1'b0;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_alu_result <= '0;
            r_data_out   <= '0;
            r_mem_write  <= 1'b0;
            r_resv_valid <= 1'b0;
            r_resv_addr  <= '0;
            // NOTE: the register file is cleared on reset, which keeps it out of RAM macros.
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else begin
            r_pc         <= w_next_pc;
            r_alu_result <= w_result;
            r_data_out   <= w_store_data;
            r_mem_write  <= w_mem_we;
            if (w_set_resv) begin
                r_resv_valid <= 1'b1;
                r_resv_addr  <= w_rs1_val;
            end else if (w_clr_resv) begin
                r_resv_valid <= 1'b0;
            end
            if (w_rd_we && w_rd != 5'd0) registers[w_rd] <= w_rd_val;
        end
    end

    logic w_unused;
    assign w_unused = ^{instr_in[63:32], w_prod_ss[XLEN-1:0], w_prod_su[XLEN-1:0]};

endmodule

// File: tb/tb_rv64ima_soc.sv
// Directed bench for rv64ima_soc: hand-assembled instructions with hand-computed results,
// checked by immediate assertions after each executing clock edge.
module tb_rv64ima_soc;

    logic        clk;
    logic        reset;
    logic [63:0] instr_in;
    logic [63:0] data_in;
    logic [63:0] pc_out;
    logic [63:0] alu_result;
    logic [63:0] data_out;
    logic        mem_write;

    int n_pass  = 0;
    int n_total = 0;

    rv64ima_soc #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_in   (instr_in),
        .data_in    (data_in),
        .pc_out     (pc_out),
        .alu_result (alu_result),
        .data_out   (data_out),
        .mem_write  (mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_amo(input logic [4:0] f5, input logic [4:0] rs2,
                                            input logic [4:0] rs1, input logic [4:0] rd);
        return {f5, 2'b00, rs2, rs1, 3'b011, rd, 7'b0101111};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [63:0] instr, input logic [63:0] din);
        @(negedge clk);
        instr_in = instr;
        data_in  = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] acc;
        reset    = 1'b1;
        instr_in = 64'h0;
        data_in  = 64'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_pc", pc_out, 64'h0);
        chk("rst_alu", alu_result, 64'h0);
        chk("rst_dout", data_out, 64'h0);
        chk("rst_mw", 64'(mem_write), 64'h0);

        reset = 1'b0;
        dut.registers[11] <= 64'd20;
        dut.registers[12] <= 64'd15;
        dut.registers[13] <= 64'd30;
        dut.registers[14] <= 64'd50;

        step({32'h0, enc_r(7'h00, 5'd12, 5'd11, 3'd0, 5'd10)}, 64'h0);
        chk("add_x10", dut.registers[10], 64'd35);
        chk("add_alu", alu_result, 64'd35);
        chk("add_pc", pc_out, 64'd4);
        step({32'h0, enc_r(7'h20, 5'd12, 5'd11, 3'd0, 5'd10)}, 64'h0);
        chk("sub_x10", dut.registers[10], 64'd5);
        step(64'h0000_0013, 64'h0);
        chk("nop_pc", pc_out, 64'd12);
        step({32'h0, enc_r(7'h00, 5'd11, 5'd10, 3'd4, 5'd11)}, 64'h0);
        chk("xor_x11", dut.registers[11], 64'd17);
        step(64'h0000_0013, 64'h0);
        chk("nop2_pc", pc_out, 64'd20);
        step({32'h0, enc_r(7'h00, 5'd12, 5'd11, 3'd6, 5'd12)}, 64'h0);
        chk("or_x12", dut.registers[12], 64'd31);
        step({32'h0, enc_r(7'h00, 5'd13, 5'd11, 3'd7, 5'd13)}, 64'h0);
        chk("and_x13", dut.registers[13], 64'd16);
        chk("and_pc", pc_out, 64'd28);

        step({32'h0, enc_r(7'h01, 5'd11, 5'd10, 3'd0, 5'd15)}, 64'h0);
        chk("mul_x15", dut.registers[15], 64'd85);
        step({32'h0, enc_r(7'h01, 5'd0, 5'd10, 3'd4, 5'd16)}, 64'h0);
        chk("div0_x16", dut.registers[16], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("div0_alu", alu_result, 64'hFFFF_FFFF_FFFF_FFFF);
        step({32'h0, enc_r(7'h01, 5'd0, 5'd10, 3'd6, 5'd17)}, 64'h0);
        chk("rem0_x17", dut.registers[17], 64'd5);

        dut.registers[20] <= 64'h8000_0000_0000_0000;
        dut.registers[21] <= 64'hFFFF_FFFF_FFFF_FFFF;
        step({32'h0, enc_r(7'h01, 5'd21, 5'd20, 3'd4, 5'd18)}, 64'h0);
        chk("divovf_x18", dut.registers[18], 64'h8000_0000_0000_0000);
        step({32'h0, enc_r(7'h01, 5'd21, 5'd20, 3'd6, 5'd19)}, 64'h0);
        chk("removf_x19", dut.registers[19], 64'h0);
        step({32'h0, enc_r(7'h01, 5'd21, 5'd21, 3'd3, 5'd22)}, 64'h0);
        chk("mulhu_x22", dut.registers[22], 64'hFFFF_FFFF_FFFF_FFFE);
        step({32'h0, enc_r(7'h01, 5'd21, 5'd20, 3'd1, 5'd23)}, 64'h0);
        chk("mulh_x23", dut.registers[23], 64'h0);
        chk("mulh_pc", pc_out, 64'd56);

        step({32'h0, enc_amo(5'b00010, 5'd0, 5'd10, 5'd4)}, 64'h10);
        chk("lr_x4", dut.registers[4], 64'h10);
        chk("lr_alu", alu_result, 64'd5);
        chk("lr_mw", 64'(mem_write), 64'h0);
        step({32'h0, enc_amo(5'b00011, 5'd12, 5'd10, 5'd4)}, 64'h0);
        chk("sc_mw", 64'(mem_write), 64'h1);
        chk("sc_dout", data_out, 64'd31);
        chk("sc_x4", dut.registers[4], 64'h0);
        step({32'h0, enc_amo(5'b00011, 5'd12, 5'd10, 5'd4)}, 64'h0);
        chk("sc2_x4", dut.registers[4], 64'h1);
        chk("sc2_mw", 64'(mem_write), 64'h0);

        step({32'h0, enc_amo(5'b00000, 5'd11, 5'd10, 5'd4)}, 64'd7);
        chk("amoadd_x4", dut.registers[4], 64'd7);
        chk("amoadd_dout", data_out, 64'd24);
        chk("amoadd_mw", 64'(mem_write), 64'h1);
        step({32'h0, enc_amo(5'b10000, 5'd11, 5'd10, 5'd4)}, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("amomin_dout", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
        step({32'h0, enc_amo(5'b11000, 5'd11, 5'd10, 5'd4)}, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("amominu_dout", data_out, 64'd17);
        chk("amominu_x4", dut.registers[4], 64'hFFFF_FFFF_FFFF_FFFF);

        step({32'h0, enc_s(12'd8, 5'd12, 5'd10, 3'b011)}, 64'h0);
        chk("sd_alu", alu_result, 64'd13);
        chk("sd_dout", data_out, 64'd31);
        chk("sd_mw", 64'(mem_write), 64'h1);
        step({32'h0, enc_i(12'd0, 5'd10, 3'b000, 5'd24, 7'b0000011)}, 64'h1234_5678_9ABC_DE80);
        chk("lb_x24", dut.registers[24], 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_mw", 64'(mem_write), 64'h0);
        step({32'h0, enc_i(12'd0, 5'd10, 3'b100, 5'd25, 7'b0000011)}, 64'h1234_5678_9ABC_DE80);
        chk("lbu_x25", dut.registers[25], 64'h80);
        step({32'h0, enc_i({6'b010000, 6'd4}, 5'd20, 3'b101, 5'd26, 7'b0010011)}, 64'h0);
        chk("srai_x26", dut.registers[26], 64'hF800_0000_0000_0000);
        chk("srai_pc", pc_out, 64'd96);

        step({32'h0, enc_b(13'd16, 5'd10, 5'd10, 3'b000)}, 64'h0);
        chk("beq_pc", pc_out, 64'd112);
        step({32'h0, enc_j(21'h1F_FFF8, 5'd1)}, 64'h0);
        chk("jal_pc", pc_out, 64'd104);
        chk("jal_x1", dut.registers[1], 64'd116);

        @(negedge clk);
        reset    = 1'b1;
        instr_in = {32'h0, enc_r(7'h00, 5'd12, 5'd11, 3'd0, 5'd10)};
        data_in  = 64'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        acc = 64'h0;
        for (int i = 0; i < 32; i++) acc = acc | dut.registers[i];
        chk("mrst_pc", pc_out, 64'h0);
        chk("mrst_regs", acc, 64'h0);
        chk("mrst_alu", alu_result, 64'h0);
        chk("mrst_dout", data_out, 64'h0);
        chk("mrst_mw", 64'(mem_write), 64'h0);

        step(64'h0, 64'h0);
        acc = 64'h0;
        for (int i = 0; i < 32; i++) acc = acc | dut.registers[i];
        chk("zero_pc", pc_out, 64'd4);
        chk("zero_regs", acc, 64'h0);
        chk("zero_alu", alu_result, 64'h0);
        step({32'hDEAD_BEEF, enc_i(12'd7, 5'd0, 3'b000, 5'd5, 7'b0010011)}, 64'h0);
        chk("addi_hi_x5", dut.registers[5], 64'd7);
        chk("addi_hi_pc", pc_out, 64'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
